// File: rtl/fp_add_seq.sv
// Multi-cycle IEEE-754 single-precision adder sequencer: unpack, align, add, iterative normalize, pack.
// Optional macro FP_ADD_SEQ_ROUND_EN adds guard/round/sticky bits and round-to-nearest-even in PACK.
module fp_add_seq #(
  parameter int unsigned EXP_W = 8,
  parameter int unsigned MAN_W = 23
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [EXP_W+MAN_W:0] in_a,
  input  logic [EXP_W+MAN_W:0] in_b,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [EXP_W+MAN_W:0] out_result,
  output logic [2:0]           out_flags,
  output logic                 busy
);
  localparam int unsigned W = 1 + EXP_W + MAN_W;
`ifdef FP_ADD_SEQ_ROUND_EN
  localparam int unsigned GRS_W = 3;
`else
  localparam int unsigned GRS_W = 0;
`endif
  localparam int unsigned H_W = MAN_W + 1;
  localparam int unsigned M_W = H_W + GRS_W;
  localparam int unsigned S_W = M_W + 1;
  localparam int unsigned SHIFT_LIM = 26;
  localparam logic [EXP_W-1:0] EXP_MAX = {EXP_W{1'b1}};

  typedef enum logic [2:0] {
    S_IDLE, S_UNPACK, S_ALIGN, S_ADD, S_NORM, S_PACK, S_DONE
  } state_e;

  state_e           state_q, state_d;
  logic [W-1:0]     a_q, a_d, b_q, b_d;
  logic             sa_q, sa_d, sb_q, sb_d;
  logic [EXP_W-1:0] ea_q, ea_d, eb_q, eb_d;
  logic [H_W-1:0]   ma_q, ma_d, mb_q, mb_d;
  logic             sign_q, sign_d, sub_q, sub_d;
  logic [EXP_W-1:0] exp_q, exp_d;
  logic [M_W-1:0]   big_q, big_d, small_q, small_d;
  logic [S_W-1:0]   man_q, man_d;
  logic [2:0]       flags_q, flags_d;
  logic             out_valid_q, out_valid_d, busy_q, busy_d;
  logic [W-1:0]     out_result_q, out_result_d;
  logic [2:0]       out_flags_q, out_flags_d;

  logic             swap;
  logic [EXP_W-1:0] diff, exp_inc;
  logic [M_W-1:0]   small_ext;
`ifdef FP_ADD_SEQ_ROUND_EN
  logic             round_up, round_carry;
  logic [MAN_W-1:0] frac_rnd;
`endif

  assign in_ready   = (state_q == S_IDLE);
  assign out_valid  = out_valid_q;
  assign out_result = out_result_q;
  assign out_flags  = out_flags_q;
  assign busy       = busy_q;

  // Next-state and datapath step for the current phase
  always_comb begin
    state_d = state_q;   a_d = a_q;     b_d = b_q;
    sa_d = sa_q;         sb_d = sb_q;   ea_d = ea_q;   eb_d = eb_q;
    ma_d = ma_q;         mb_d = mb_q;   sign_d = sign_q; sub_d = sub_q;
    exp_d = exp_q;       big_d = big_q; small_d = small_q; man_d = man_q;
    flags_d = flags_q;   out_valid_d = out_valid_q;
    out_result_d = out_result_q; out_flags_d = out_flags_q;
    swap      = ({ea_q, ma_q} < {eb_q, mb_q});
    diff      = swap ? (eb_q - ea_q) : (ea_q - eb_q);
    small_ext = M_W'(swap ? ma_q : mb_q) << GRS_W;
    exp_inc   = exp_q + EXP_W'(1);
`ifdef FP_ADD_SEQ_ROUND_EN
    round_up    = man_q[2] & (man_q[1] | man_q[0] | man_q[GRS_W]);
    round_carry = round_up & (&man_q[M_W-2:GRS_W]);
    frac_rnd    = man_q[M_W-2:GRS_W] + MAN_W'(round_up);
`endif
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          a_d = in_a;
          b_d = in_b;
          state_d = S_UNPACK;
        end
      end
      S_UNPACK: begin
        sa_d = a_q[W-1];
        sb_d = b_q[W-1];
        ea_d = a_q[W-2:MAN_W];
        eb_d = b_q[W-2:MAN_W];
        ma_d = (a_q[W-2:MAN_W] != '0) ? {1'b1, a_q[MAN_W-1:0]} : '0;
        mb_d = (b_q[W-2:MAN_W] != '0) ? {1'b1, b_q[MAN_W-1:0]} : '0;
        flags_d = 3'b000;
        state_d = S_ALIGN;
        // Inf/NaN on either side yields the canonical quiet NaN
        if (a_q[W-2:MAN_W] == EXP_MAX || b_q[W-2:MAN_W] == EXP_MAX) begin
          sign_d  = 1'b0;
          exp_d   = EXP_MAX;
          man_d   = S_W'(1) << (M_W - 2);
          flags_d = 3'b100;
          state_d = S_PACK;
        end
      end
      S_ALIGN: begin
        sign_d = swap ? sb_q : sa_q;
        exp_d  = swap ? eb_q : ea_q;
        big_d  = M_W'(swap ? mb_q : ma_q) << GRS_W;
        sub_d  = sa_q ^ sb_q;
        if (diff >= EXP_W'(SHIFT_LIM)) begin
          small_d = '0;
        end else begin
          small_d = small_ext >> diff;
`ifdef FP_ADD_SEQ_ROUND_EN
          small_d[0] = small_d[0] | (|(small_ext & ~({M_W{1'b1}} << diff)));
`endif
        end
        state_d = S_ADD;
      end
      S_ADD: begin
        man_d = sub_q ? ({1'b0, big_q} - {1'b0, small_q}) : ({1'b0, big_q} + {1'b0, small_q});
        state_d = S_NORM;
      end
      S_NORM: begin
        state_d = S_PACK;
        if (man_q == '0) begin
          sign_d = 1'b0;
          exp_d  = '0;
          flags_d[0] = 1'b1;
        end else if (man_q[S_W-1]) begin
          man_d = man_q >> 1;
`ifdef FP_ADD_SEQ_ROUND_EN
          man_d[0] = man_q[1] | man_q[0];
`endif
          exp_d = exp_inc;
          if (exp_inc == EXP_MAX) begin
            man_d = '0;
            flags_d[1] = 1'b1;
          end
        end else if (!man_q[M_W-1]) begin
          // Below the normal range: flush to signed zero instead of producing a denormal
          if (exp_q == EXP_W'(1)) begin
            man_d = '0;
            exp_d = '0;
            flags_d[0] = 1'b1;
          end else begin
            man_d   = man_q << 1;
            exp_d   = exp_q - EXP_W'(1);
            state_d = S_NORM;
          end
        end
      end
      S_PACK: begin
`ifdef FP_ADD_SEQ_ROUND_EN
        if (round_carry) begin
          exp_d = exp_inc;
          man_d = S_W'(1) << (M_W - 1);
          if (exp_inc == EXP_MAX) begin
            man_d = '0;
            flags_d[1] = 1'b1;
          end
        end else begin
          out_result_d = {sign_q, exp_q, frac_rnd};
          out_flags_d  = flags_q;
          state_d      = S_DONE;
        end
`else
        out_result_d = {sign_q, exp_q, man_q[M_W-2:0]};
        out_flags_d  = flags_q;
        state_d      = S_DONE;
`endif
      end
      S_DONE: begin
        if (out_valid_q && out_ready) begin
          out_valid_d = 1'b0;
          state_d     = S_IDLE;
        end else begin
          out_valid_d = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;  a_q <= '0;  b_q <= '0;
      sa_q <= 1'b0;  sb_q <= 1'b0;  ea_q <= '0;  eb_q <= '0;
      ma_q <= '0;  mb_q <= '0;  sign_q <= 1'b0;  sub_q <= 1'b0;
      exp_q <= '0;  big_q <= '0;  small_q <= '0;  man_q <= '0;
      flags_q <= '0;  out_valid_q <= 1'b0;  busy_q <= 1'b0;
      out_result_q <= '0;  out_flags_q <= '0;
    end else begin
      state_q <= state_d;  a_q <= a_d;  b_q <= b_d;
      sa_q <= sa_d;  sb_q <= sb_d;  ea_q <= ea_d;  eb_q <= eb_d;
      ma_q <= ma_d;  mb_q <= mb_d;  sign_q <= sign_d;  sub_q <= sub_d;
      exp_q <= exp_d;  big_q <= big_d;  small_q <= small_d;  man_q <= man_d;
      flags_q <= flags_d;  out_valid_q <= out_valid_d;  busy_q <= busy_d;
      out_result_q <= out_result_d;  out_flags_q <= out_flags_d;
    end
  end

endmodule

// File: tb/tb_fp_add_seq.sv
// Bench for fp_add_seq: directed cases, handshake/reset behaviour and randomized ops against a numeric model.
module tb_fp_add_seq;
`ifdef FP_ADD_SEQ_ROUND_EN
  localparam int G = 3;
`else
  localparam int G = 0;
`endif

  logic        clk, rst_n, in_valid, in_ready, out_valid, out_ready, busy;
  logic [31:0] in_a, in_b, out_result;
  logic [2:0]  out_flags;
  int          checks, errors;

  fp_add_seq dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_flags(out_flags), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Numeric model: magnitude-ordered add/sub on integer significands, then normalize/round by value
  function automatic void ref_add(input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] res, output logic [2:0] fl, output int lat);
    logic [31:0] x, y;
    longint ka, kb, mx, my, s, hid, lost, frac, gb;
    int ex, ey, e, d, k;
    bit sg, special;
    res = '0; fl = 3'b000; lat = 0;
    if (a[30:23] == 8'hFF || b[30:23] == 8'hFF) begin
      res = 32'h7FC00000; fl = 3'b100; lat = 3;
      return;
    end
    ka = (a[30:23] == 8'd0) ? 0 : longint'({a[30:23], 1'b1, a[22:0]});
    kb = (b[30:23] == 8'd0) ? 0 : longint'({b[30:23], 1'b1, b[22:0]});
    if (ka >= kb) begin x = a; y = b; end else begin x = b; y = a; end
    ex = int'(x[30:23]); ey = int'(y[30:23]);
    mx = (ex == 0) ? 0 : ((64'd1 << 23) | longint'(x[22:0]));
    my = (ey == 0) ? 0 : ((64'd1 << 23) | longint'(y[22:0]));
    mx = mx << G; my = my << G;
    d = ex - ey;
    if (d >= 26) my = 0;
    else begin
      lost = my & ((64'd1 << d) - 1);
      my = my >> d;
      if (G > 0 && lost != 0) my = my | 1;
    end
    s = (x[31] != y[31]) ? mx - my : mx + my;
    sg = x[31]; e = ex; hid = 64'd1 << (23 + G); k = 1; special = 0;
    if (s == 0) begin
      res = '0; fl = 3'b001; special = 1;
    end else if (s >= 2 * hid) begin
      s = (s >> 1) | ((G > 0) ? (s & 1) : 0);
      e++;
      if (e == 255) begin res = {sg, 8'hFF, 23'd0}; fl = 3'b010; special = 1; end
    end else begin
      while (s < hid && e > 1) begin s = s << 1; e--; k++; end
      if (s < hid) begin res = {sg, 31'd0}; fl = 3'b001; special = 1; end
    end
    lat = k + 5;
    if (!special) begin
      frac = s >> G;
      if (G > 0) begin
        gb = s & 7;
        if (gb > 4 || (gb == 4 && frac[0])) frac++;
        if (frac >= (64'd1 << 24)) begin
          frac = frac >> 1; e++; lat++;
          if (e == 255) begin res = {sg, 8'hFF, 23'd0}; fl = 3'b010; return; end
        end
      end
      res = {sg, e[7:0], frac[22:0]};
    end
  endfunction

  task automatic do_op(input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] r, output logic [2:0] f, output int lat);
    @(negedge clk);
    check("idle_in_ready", {63'd0, in_ready}, 64'd1);
    in_a = a; in_b = b; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 100) begin
      @(posedge clk); #1; lat++;
    end
    check("out_valid_seen", {63'd0, out_valid}, 64'd1);
    r = out_result; f = out_flags;
    repeat ($urandom_range(0, 2)) @(posedge clk);
    @(negedge clk) out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    check("hs_valid_clr", {63'd0, out_valid}, 64'd0);
    check("hs_in_ready", {63'd0, in_ready}, 64'd1);
  endtask

  logic [31:0] r, er;
  logic [2:0]  f, ef;
  int          lat, elat;

  initial begin
    checks = 0; errors = 0;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_a = '0; in_b = '0;
    #12;
    check("rst_out_valid", {63'd0, out_valid}, 64'd0);
    check("rst_out_result", {32'd0, out_result}, 64'd0);
    check("rst_out_flags", {61'd0, out_flags}, 64'd0);
    check("rst_busy", {63'd0, busy}, 64'd0);
    check("rst_in_ready", {63'd0, in_ready}, 64'd1);
    @(negedge clk) rst_n = 1'b1;

    do_op(32'h3F800000, 32'h3F800000, r, f, lat);
    check("one_plus_one", {32'd0, r}, 64'h40000000);
    check("one_plus_one_flags", {61'd0, f}, 64'd0);
    check("one_plus_one_lat", 64'(lat), 64'd6);
    do_op(32'h3FC00000, 32'hBF800000, r, f, lat);
    check("sub_half", {32'd0, r}, 64'h3F000000);
    check("sub_half_lat", 64'(lat), 64'd7);
    do_op(32'h3F800000, 32'hBF800000, r, f, lat);
    check("cancel_res", {32'd0, r}, 64'h0);
    check("cancel_flags", {61'd0, f}, 64'b001);
    do_op(32'h7F800000, 32'h3F800000, r, f, lat);
    check("inf_nan_res", {32'd0, r}, 64'h7FC00000);
    check("inf_nan_flags", {61'd0, f}, 64'b100);
    do_op(32'h7F7FFFFF, 32'h7F7FFFFF, r, f, lat);
    check("ovf_res", {32'd0, r}, 64'h7F800000);
    check("ovf_flags", {61'd0, f}, 64'b010);
    do_op(32'h3F800000, 32'h33C00000, r, f, lat);
`ifdef FP_ADD_SEQ_ROUND_EN
    check("round_up", {32'd0, r}, 64'h3F800001);
`else
    check("round_up", {32'd0, r}, 64'h3F800000);
`endif
    do_op(32'h3F800000, 32'h33800000, r, f, lat);
    check("round_tie", {32'd0, r}, 64'h3F800000);

    // Backpressure: result held while consumer stalls; new operands ignored while busy
    @(negedge clk);
    in_a = 32'h3F800000; in_b = 32'h3FC00000; in_valid = 1'b1;
    @(posedge clk);
    #1 in_a = 32'h40400000; in_b = 32'h40400000;
    lat = 0;
    while (!out_valid && lat < 100) begin @(posedge clk); #1; lat++; end
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      check("bp_valid", {63'd0, out_valid}, 64'd1);
      check("bp_result", {32'd0, out_result}, 64'h40200000);
      check("bp_in_ready", {63'd0, in_ready}, 64'd0);
    end
    @(negedge clk) begin in_valid = 1'b0; out_ready = 1'b1; end
    @(posedge clk);
    #1 out_ready = 1'b0;
    check("bp_release", {63'd0, out_valid}, 64'd0);

    // Asynchronous reset in the middle of a long normalization
    @(negedge clk);
    in_a = 32'h3F800001; in_b = 32'hBF800000; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check("norm_busy", {63'd0, busy}, 64'd1);
    rst_n = 1'b0;
    #1;
    check("midrst_valid", {63'd0, out_valid}, 64'd0);
    check("midrst_busy", {63'd0, busy}, 64'd0);
    @(negedge clk) rst_n = 1'b1;
    repeat (30) @(posedge clk);
    #1;
    check("postrst_no_result", {63'd0, out_valid}, 64'd0);
    check("postrst_in_ready", {63'd0, in_ready}, 64'd1);

    for (int n = 0; n < 300; n++) begin
      logic [31:0] a, b;
      int ea, eb, mode;
      a = $urandom; b = $urandom;
      ea = int'($urandom_range(1, 254));
      mode = int'($urandom_range(0, 6));
      case (mode)
        0: eb = ea + int'($urandom_range(0, 4)) - 2;
        1: eb = ea - int'($urandom_range(20, 30));
        2: eb = 0;
        3: begin ea = int'($urandom_range(250, 254)); eb = ea; end
        4: eb = ($urandom_range(0, 9) == 0) ? 255 : ea;
        5: begin ea = int'($urandom_range(1, 4)); eb = ea; end
        default: eb = int'($urandom_range(0, 255));
      endcase
      if (eb < 0) eb = 0;
      if (eb > 255) eb = 255;
      a[30:23] = 8'(ea);
      b[30:23] = 8'(eb);
      if (mode == 4 || mode == 5) b = {~a[31], a[30:8], 8'($urandom)};
      ref_add(a, b, er, ef, elat);
      do_op(a, b, r, f, lat);
      check("rand_res", {32'd0, r}, {32'd0, er});
      check("rand_flags", {61'd0, f}, {61'd0, ef});
      check("rand_lat", 64'(lat), 64'(elat));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/fp_add_seq.md
Name: fp_add_seq

Overview:
Multi-cycle controller and sequencer for the single-precision floating-point adder datapath. It accepts an operand pair over a valid/ready handshake and steps an FSM through unpack, align, add/subtract, iterative normalization and pack. It presents the packed IEEE-754 result over a second valid/ready handshake. Only one operation is in flight at a time; it sits between the issue logic and the result writeback.

Parameters:
EXP_W, 8, exponent field width
MAN_W, 23, stored mantissa field width (hidden bit excluded); word width = 1+EXP_W+MAN_W

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  operand pair valid
in_ready  out  1  block can accept operands (high only in IDLE)
in_a  in  32  operand A, IEEE-754 single
in_b  in  32  operand B, IEEE-754 single
out_valid  out  1  result valid, held until accepted
out_ready  in  1  consumer accepts result
out_result  out  32  packed result
out_flags  out  3  {invalid, overflow, zero}, valid with out_valid
busy  out  1  high in every state except IDLE

Behaviour:
- Reset (async, rst_n low): state=IDLE, out_valid=0, out_result=0, out_flags=0, busy=0, all internal registers 0. Reset mid-operation aborts the operation; no result is produced.
- in_ready = (state==IDLE), combinational. Accept on in_valid&&in_ready: latch in_a and in_b, then go to UNPACK.
- UNPACK (1 cycle): split sign, exp and mantissa. Hidden bit = (exp!=0). exp==0 operands are treated as zero (no denormal support). If either exp==all-ones: result=0x7FC00000, invalid=1, go to PACK.
- ALIGN (1 cycle): order the operands by magnitude, comparing {exp, mantissa}; big takes the larger. Right-shift the small mantissa by exp_diff; exp_diff>=26 gives 0. do_subtract = sign_a ^ sign_b. Result sign = big sign.
- ADD (1 cycle): 25-bit sum = big_man ± small_man.
- NORM (k>=1 cycles; each cycle either does one shift or exits):
  - sum==0: result +0 (sign 0), zero=1, exit.
  - bit24 set: shift right 1 and exp+1 in the same cycle, then exit. If the new exp == all-ones: result = ±inf, overflow=1.
  - bit23 clear: shift left 1, exp-1, stay in NORM.
  - bit23 set: exit.
  - exp reaches 1 with bit23 still clear: flush to signed zero, zero=1, exit.
  - Maximum k = 24.
- PACK (1 cycle): assemble {sign, exp, man[22:0]} into out_result, then go to DONE.
- DONE: out_valid=1; out_result and out_flags are held stable. On out_ready, clear out_valid and go to IDLE. A new operand can be accepted no earlier than the cycle after that handshake.
- Latency: out_valid rises k+5 rising edges after the accept edge.
- in_valid is ignored outside IDLE. out_ready is ignored outside DONE.

Optional Feature:
Macro: FP_ADD_SEQ_ROUND_EN.
- Defined: the datapath carries 3 extra bits (guard, round, sticky) through ALIGN, ADD and NORM. PACK applies round-to-nearest-even. A rounding carry-out renormalizes in PACK (PACK becomes 2 cycles only when a carry occurs); the overflow rule is the same as in NORM.
- Undefined: bits shifted out are discarded (truncation); PACK is always 1 cycle.

Test Plan:
- 0x3F800000 + 0x3F800000 (1.0+1.0) -> out_result=0x40000000, flags=000, out_valid 6 edges after accept (k=1).
- 0x3FC00000 + 0xBF800000 (1.5-1.0) -> 0x3F000000, k=2, out_valid 7 edges after accept.
- 0x3F800000 + 0xBF800000 -> 0x00000000, flags=001 (zero).
- 0x7F800000 + 0x3F800000 -> 0x7FC00000, flags=100. 0x7F7FFFFF + 0x7F7FFFFF -> 0x7F800000, flags=010.
- 0x3F800000 + 0x33C00000 -> 0x3F800001 with FP_ADD_SEQ_ROUND_EN, 0x3F800000 without. 0x3F800000 + 0x33800000 (tie) -> 0x3F800000 in both builds.
- Backpressure/reset: hold out_ready=0 for 10 cycles -> out_valid and out_result stable, in_ready=0. Then assert rst_n=0 while in NORM -> out_valid=0 and busy=0 immediately; after release in_ready=1.
